// File: rtl/f_fetch_unit.sv
// f_fetch_unit -- instruction fetch stage.
//
// Holds the fetch PC, issues word-aligned requests to instruction memory and
// buffers the in-order responses in a small queue. The head of the queue is
// decoded combinationally into the f_* fields latched by the F->D register.
// Prediction is static not-taken (f_delayPC_o = f_pc_o + 4).
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   D_stall_i            D register holding; queue head is not consumed
//   redirect_i           flush and refetch from redirect_pc_i (word aligned)
//   imem_req_*           request channel (valid/ready handshake, address)
//   imem_rsp_*           response channel, in order, no backpressure
//   f_*                  decoded head instruction; bubble encoding when empty
//   f_empty_o            queue empty
module f_fetch_unit #(
  parameter int                  PC_WIDTH  = 64,
  parameter int                  CPU_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(64'h8000_0000),
  parameter int                  IQ_DEPTH  = 2,
  parameter logic [4:0]          RNONE     = 5'd0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 D_stall_i,
  input  logic                 redirect_i,
  input  logic [PC_WIDTH-1:0]  redirect_pc_i,
  output logic                 imem_req_valid_o,
  input  logic                 imem_req_ready_i,
  output logic [PC_WIDTH-1:0]  imem_req_addr_o,
  input  logic                 imem_rsp_valid_i,
  input  logic [31:0]          imem_rsp_data_i,
  output logic [6:0]           f_opcode_o,
  output logic [4:0]           f_rd_o,
  output logic [4:0]           f_rs1_o,
  output logic [4:0]           f_rs2_o,
  output logic [2:0]           f_func3_o,
  output logic [6:0]           f_func7_o,
  output logic [11:0]          f_imm_o,
  output logic [PC_WIDTH-1:0]  f_pc_o,
  output logic [CPU_WIDTH-1:0] f_valC_o,
  output logic [PC_WIDTH-1:0]  f_delayPC_o,
  output logic                 f_empty_o
);

  localparam int AW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Sign-extended immediate chosen by opcode; R-type and unknown give 0.
  function automatic logic signed [CPU_WIDTH-1:0] imm_of(input logic [31:0] inst);
    logic signed [31:0] imm32;
    case (inst[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67: imm32 = {{20{inst[31]}}, inst[31:20]};
      7'h23:                      imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'h63:                      imm32 = {{19{inst[31]}}, inst[31], inst[7],
                                           inst[30:25], inst[11:8], 1'b0};
      7'h37, 7'h17:               imm32 = {inst[31:12], 12'h000};
      7'h6f:                      imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                                           inst[20], inst[30:21], 1'b0};
      default:                    imm32 = '0;
    endcase
    return CPU_WIDTH'(imm32);
  endfunction

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pc_tail;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       live;
  logic [CW-1:0]       drop;
  logic [31:0]         inst_q [IQ_DEPTH];
  logic [PC_WIDTH-1:0] pc_q   [IQ_DEPTH];

  logic                credit_ok;
  logic                req_fire;
  logic                drop_nz;
  logic                rsp_push;
  logic                pop;
  logic [PC_WIDTH-1:0] target_pc;
  logic [31:0]         head_inst;
  logic [PC_WIDTH-1:0] head_pc;

  // Queued entries plus in-flight requests never exceed the queue size, so a
  // response can always be accepted without backpressure.
  assign credit_ok        = ({1'b0, count} + {1'b0, live}) < (CW + 1)'(IQ_DEPTH);
  assign imem_req_valid_o = !rst_i && !redirect_i && credit_ok;
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign drop_nz          = (drop != '0);
  assign rsp_push         = imem_rsp_valid_i && !drop_nz && !redirect_i;
  assign pop              = (count != '0) && !D_stall_i && !redirect_i;
  assign target_pc        = redirect_pc_i & ~PC_WIDTH'(3);
  assign head_inst        = inst_q[rd_ptr];
  assign head_pc          = pc_q[rd_ptr];
  assign f_empty_o        = (count == '0);

  // Control state: PCs, pointers and credit counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      pc_tail  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= '0;
    end else if (redirect_i) begin
      // Every request still in flight now belongs to the wrong path; a
      // response arriving this cycle already retires one of them.
      fetch_pc <= target_pc;
      pc_tail  <= target_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= drop + live - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_WIDTH'(4);
      if (rsp_push) begin
        pc_tail <= pc_tail + PC_WIDTH'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(rsp_push) - CW'(pop);
      live  <= live + CW'(req_fire) - CW'(imem_rsp_valid_i && !drop_nz);
      drop  <= drop - CW'(imem_rsp_valid_i && drop_nz);
    end
  end

  // Queue storage: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && rsp_push) begin
      inst_q[wr_ptr] <= imem_rsp_data_i;
      pc_q[wr_ptr]   <= pc_tail;
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_push && !pop && (count == CW'(IQ_DEPTH))));

  // Head decode; empty queue presents the bubble encoding.
  always_comb begin
    f_opcode_o  = '0;
    f_rd_o      = RNONE;
    f_rs1_o     = RNONE;
    f_rs2_o     = RNONE;
    f_func3_o   = '0;
    f_func7_o   = '0;
    f_imm_o     = '0;
    f_pc_o      = '0;
    f_valC_o    = '0;
    f_delayPC_o = '0;
    if (!f_empty_o) begin
      f_opcode_o  = head_inst[6:0];
      f_rd_o      = head_inst[11:7];
      f_rs1_o     = head_inst[19:15];
      f_rs2_o     = head_inst[24:20];
      f_func3_o   = head_inst[14:12];
      f_func7_o   = head_inst[31:25];
      f_imm_o     = head_inst[31:20];
      f_pc_o      = head_pc;
      f_valC_o    = imm_of(head_inst);
      f_delayPC_o = head_pc + PC_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Testbench for f_fetch_unit: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_f_fetch_unit;

  localparam int         DEPTH = 2;
  localparam logic [4:0] RNONE = 5'd0;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        D_stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic [6:0]  f_opcode_o;
  logic [4:0]  f_rd_o, f_rs1_o, f_rs2_o;
  logic [2:0]  f_func3_o;
  logic [6:0]  f_func7_o;
  logic [11:0] f_imm_o;
  logic [63:0] f_pc_o, f_valC_o, f_delayPC_o;
  logic        f_empty_o;

  f_fetch_unit #(.PC_WIDTH(64), .CPU_WIDTH(64), .RESET_PC(RST_PC),
                 .IQ_DEPTH(DEPTH), .RNONE(RNONE)) dut (
    .clk_i(clk), .rst_i(rst_i), .D_stall_i(D_stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .f_opcode_o(f_opcode_o), .f_rd_o(f_rd_o), .f_rs1_o(f_rs1_o), .f_rs2_o(f_rs2_o),
    .f_func3_o(f_func3_o), .f_func7_o(f_func7_o), .f_imm_o(f_imm_o),
    .f_pc_o(f_pc_o), .f_valC_o(f_valC_o), .f_delayPC_o(f_delayPC_o),
    .f_empty_o(f_empty_o));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int rsp_pct = 100;

  // Reference model state
  logic [63:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [63:0] fetch_pc, pc_tail;
  int          live, drop;
  logic        exp_valid = 1'b0;
  // imem model: outstanding accepted requests, oldest first
  logic [63:0] pend_addr[$];
  int          pend_acc[$];

  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a[4:2])
      3'd0: return 32'h0050_0093;   // addi x1,x0,5
      3'd1: return 32'hFFF0_0093;   // addi x1,x0,-1
      3'd2: return 32'hFE00_0EE3;   // beq, offset -4
      3'd3: return 32'h1234_5037;   // lui
      3'd4: return 32'h00B5_0533;   // add (R-type)
      3'd5: return 32'h0011_2423;   // sw ra,8(sp)
      3'd6: return 32'h0080_00EF;   // jal ra,+8
      default: return 32'hFFDF_F06F; // jal x0, negative
    endcase
  endfunction

  // Immediate value from the ISA field definitions, using plain arithmetic.
  function automatic logic [63:0] ref_valc(input logic [31:0] i);
    longint v;
    case (i[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67: begin
        v = longint'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        v = longint'(i[31:12]);
        if (v >= 524288) v -= 1048576;
        v = v * 4096;
      end
      7'h6f: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic        fire;
    logic [63:0] addr;
    fire = exp_valid && imem_req_ready_i;
    addr = fetch_pc;
    if (rst_i) begin
      q_pc.delete(); q_inst.delete(); pend_addr.delete(); pend_acc.delete();
      fetch_pc = RST_PC; pc_tail = RST_PC; live = 0; drop = 0;
    end else begin
      if (redirect_i) begin
        drop = drop + live - (imem_rsp_valid_i ? 1 : 0);
        live = 0;
        q_pc.delete(); q_inst.delete();
        fetch_pc = redirect_pc_i & ~64'd3;
        pc_tail  = fetch_pc;
      end else begin
        if (q_pc.size() > 0 && !D_stall_i) begin
          void'(q_pc.pop_front()); void'(q_inst.pop_front());
        end
        if (imem_rsp_valid_i) begin
          if (drop > 0) drop--;
          else begin
            q_pc.push_back(pc_tail); q_inst.push_back(imem_rsp_data_i);
            pc_tail += 64'd4; live--;
          end
        end
        if (fire) begin live++; fetch_pc += 64'd4; end
      end
      if (imem_rsp_valid_i) begin void'(pend_addr.pop_front()); void'(pend_acc.pop_front()); end
      if (fire) begin pend_addr.push_back(addr); pend_acc.push_back(cyc_n); end
    end
  endtask

  task automatic model_check();
    logic [31:0] inst;
    logic [63:0] epc;
    logic        emp;
    exp_valid = !rst_i && !redirect_i && (q_pc.size() + live < DEPTH);
    chk("req_valid", 64'(imem_req_valid_o), 64'(exp_valid));
    if (exp_valid) chk("req_addr", imem_req_addr_o, fetch_pc);
    emp = (q_pc.size() == 0);
    chk("empty", 64'(f_empty_o), 64'(emp));
    if (!emp) begin
      inst = q_inst[0]; epc = q_pc[0];
      chk("opcode", 64'(f_opcode_o), 64'(inst[6:0]));
      chk("rd",     64'(f_rd_o),     64'(inst[11:7]));
      chk("rs1",    64'(f_rs1_o),    64'(inst[19:15]));
      chk("rs2",    64'(f_rs2_o),    64'(inst[24:20]));
      chk("func3",  64'(f_func3_o),  64'(inst[14:12]));
      chk("func7",  64'(f_func7_o),  64'(inst[31:25]));
      chk("imm",    64'(f_imm_o),    64'(inst[31:20]));
      chk("pc",     f_pc_o,          epc);
      chk("valC",   f_valC_o,        ref_valc(inst));
      chk("delayPC", f_delayPC_o,    epc + 64'd4);
    end else begin
      chk("bub_opcode", 64'(f_opcode_o), 64'd0);
      chk("bub_rd",  64'(f_rd_o),  64'(RNONE));
      chk("bub_rs1", 64'(f_rs1_o), 64'(RNONE));
      chk("bub_rs2", 64'(f_rs2_o), 64'(RNONE));
      chk("bub_f3f7imm", {f_func3_o, f_func7_o, f_imm_o}, 64'd0);
      chk("bub_pc",  f_pc_o, 64'd0);
      chk("bub_valC", f_valC_o, 64'd0);
      chk("bub_delayPC", f_delayPC_o, 64'd0);
    end
  endtask

  // One clock cycle: retire the previous cycle into the model, drive the new
  // inputs (imem response from the pending list), then check mid-cycle.
  task automatic cyc(input logic r, input logic st, input logic rdr,
                     input logic [63:0] rpc, input logic rdy);
    @(posedge clk);
    model_update();
    cyc_n++;
    #1;
    rst_i = r; D_stall_i = st; redirect_i = rdr; redirect_pc_i = rpc;
    imem_req_ready_i = rdy;
    if (pend_addr.size() > 0 && pend_acc[0] < cyc_n &&
        $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = mem(pend_addr[0]);
    end else begin
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = $urandom;
    end
    #3;
    model_check();
  endtask

  logic [63:0] t5_pc [5];
  logic [63:0] t5_v  [5];

  initial begin
    t5_pc = '{64'h8000_0004, 64'h8000_0008, 64'h8000_000C, 64'h8000_0014, 64'h8000_0018};
    t5_v  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
              64'h0000_0000_1234_5000, 64'd8, 64'd8};

    // T1: reset, then first fetch with single-cycle imem
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("t1_rst_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t1_rst_empty", 64'(f_empty_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_addr", imem_req_addr_o, 64'h8000_0000);
    cyc(0, 0, 0, 0, 1);
    chk("t1_empty_c2", 64'(f_empty_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_opcode", 64'(f_opcode_o), 64'h13);
    chk("t1_rd", 64'(f_rd_o), 64'd1);
    chk("t1_valC", f_valC_o, 64'd5);
    chk("t1_pc", f_pc_o, 64'h8000_0000);
    chk("t1_delayPC", f_delayPC_o, 64'h8000_0004);

    // T2: stall with imem streaming, then release
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);
    chk("t2_held_pc", f_pc_o, 64'h8000_0000);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

    // T3: redirect with two requests live; their responses are dropped
    cyc(1, 0, 0, 0, 1);
    rsp_pct = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 64'h8000_0101, 1);
    chk("t3_redir_valid", 64'(imem_req_valid_o), 64'd0);
    rsp_pct = 100;
    cyc(0, 0, 0, 0, 1);
    chk("t3_addr", imem_req_addr_o, 64'h8000_0100);
    chk("t3_empty_a", 64'(f_empty_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_empty_b", 64'(f_empty_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_empty_c", 64'(f_empty_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc", f_pc_o, 64'h8000_0100);

    // T4: redirect in the same cycle as a response and ready
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 64'h8000_0040, 1);
    chk("t4_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t4_rsp_present", 64'(imem_rsp_valid_i), 64'd1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_pc", f_pc_o, 64'h8000_0040);

    // T5: immediates, each fetched alone after a redirect
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 1);
      cyc(0, 1, 1, t5_pc[i], 1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      chk("t5_pc", f_pc_o, t5_pc[i]);
      chk("t5_valC", f_valC_o, t5_v[i]);
    end

    // T6: ready low holds the request; reset mid-stream
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 64'h8000_0200, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t6_hold_valid", 64'(imem_req_valid_o), 64'd1);
      chk("t6_hold_addr", imem_req_addr_o, 64'h8000_0200);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("t6_rst_valid", 64'(imem_req_valid_o), 64'd0);
    cyc(0, 1, 0, 0, 1);
    chk("t6_empty", 64'(f_empty_o), 64'd1);
    chk("t6_opcode", 64'(f_opcode_o), 64'd0);
    chk("t6_addr", imem_req_addr_o, 64'h8000_0000);

    // Randomized traffic including wrap-around redirect targets
    rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      if ($urandom_range(3) == 0) rpc = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | 32'($urandom_range(31))};
      else rpc = {32'h8000_0000, $urandom};
      cyc($urandom_range(99) < 1, $urandom_range(99) < 30, $urandom_range(99) < 5,
          rpc, $urandom_range(99) < 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
